// File: rtl/vga_linefetch_if.sv
// Scanline fetch bundle: timing-generator handshake (newline/advance/line/pixel) plus the memory read port.
// master = fetch controller side, slave = timing generator / memory side.
interface vga_linefetch_if #(
   parameter int ADDR_W = 17
);
   logic              newline;
   logic              advance;
   logic [7:0]        line;
   logic [11:0]       pixel;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [11:0]       mem_rdata;
   logic              busy;
   logic              overrun;

   modport master (
      input  newline, advance, line, mem_ack, mem_rdata,
      output pixel, mem_req, mem_addr, busy, overrun
   );

   modport slave (
      output newline, advance, line, mem_ack, mem_rdata,
      input  pixel, mem_req, mem_addr, busy, overrun
   );
endinterface

// File: rtl/vga_linefetch.sv
// Ping-pong line fetch for a 2x-doubled 320x240 framebuffer; pixel is combinational from the display bank,
// memory requests hold until mem_ack. Define VGA_LINEFETCH_SKIP_EN to skip refetching a line already in its bank.
module vga_linefetch #(
   parameter int                ADDR_W = 17,
   parameter logic [ADDR_W-1:0] BASE   = '0,
   parameter int                LINES  = 240,
   parameter int                WIDTH  = 320
) (
   input logic             clk,
   input logic             reset,
   vga_linefetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, RESTART} state_t;

   state_t          state_q, state_d;
   logic [7:0]      tgt_q, tgt_d;
   logic [7:0]      pend_q, pend_d;
   logic            pend_vld_q, pend_vld_d;
   logic [8:0]      idx_q, idx_d;
   logic [1:0][7:0] tag_q, tag_d;
   logic [1:0]      tag_vld_q, tag_vld_d;
   logic            ovr_q, ovr_d;
   logic [9:0]      xcnt_q, xcnt_d;

   logic [11:0]     line_buf [2][WIDTH];
   logic            wr_en;
   logic [7:0]      nl_tgt;
   logic [7:0]      start_t;
   logic            start_req;
   logic            skip_hit;
   logic            disp_bank;
   logic            disp_hit;

   assign nl_tgt = bus.line + 8'd1;

   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      idx_d      = idx_q;
      tag_d      = tag_q;
      tag_vld_d  = tag_vld_q;
      ovr_d      = ovr_q;
      wr_en      = 1'b0;
      start_req  = 1'b0;
      start_t    = nl_tgt;
      skip_hit   = 1'b0;

      case (state_q)
         IDLE: begin
            start_req = bus.newline;
         end
         FETCH: begin
            if (bus.newline) begin
               ovr_d      = 1'b1;
               pend_vld_d = 1'b1;
               pend_d     = nl_tgt;
            end
            // An interrupted fill still waits for its outstanding ack, then drops the data.
            if (bus.mem_ack) begin
               if (pend_vld_q || bus.newline) begin
                  state_d = RESTART;
               end else begin
                  wr_en = 1'b1;
                  idx_d = idx_q + 9'd1;
                  if (idx_q == 9'(WIDTH - 1)) begin
                     tag_d[tgt_q[0]]     = tgt_q;
                     tag_vld_d[tgt_q[0]] = 1'b1;
                     state_d             = IDLE;
                  end
               end
            end
         end
         RESTART: begin
            state_d    = IDLE;
            pend_vld_d = 1'b0;
            start_req  = 1'b1;
            start_t    = bus.newline ? nl_tgt : pend_q;
         end
         default: state_d = IDLE;
      endcase

`ifdef VGA_LINEFETCH_SKIP_EN
      skip_hit = tag_vld_q[start_t[0]] && (tag_q[start_t[0]] == start_t);
`else
      skip_hit = 1'b0;
`endif

      if (start_req && (int'(start_t) < LINES) && !skip_hit) begin
         state_d                = FETCH;
         tgt_d                  = start_t;
         idx_d                  = '0;
         tag_vld_d[start_t[0]]  = 1'b0;
      end
   end

   always_comb begin
      xcnt_d = xcnt_q;
      if (bus.newline) begin
         xcnt_d = '0;
      end else if (bus.advance && (xcnt_q != 10'(2 * WIDTH - 1))) begin
         xcnt_d = xcnt_q + 10'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tgt_q      <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         idx_q      <= '0;
         tag_q      <= '0;
         tag_vld_q  <= '0;
         ovr_q      <= 1'b0;
         xcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         idx_q      <= idx_d;
         tag_q      <= tag_d;
         tag_vld_q  <= tag_vld_d;
         ovr_q      <= ovr_d;
         xcnt_q     <= xcnt_d;
      end
   end

   // Fill bank and display bank always differ, so the two ports never collide.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_buf[tgt_q[0]][idx_q] <= bus.mem_rdata;
      end
   end

   assign disp_bank = bus.line[0];
   assign disp_hit  = tag_vld_q[disp_bank] && (tag_q[disp_bank] == bus.line);
   assign bus.pixel = disp_hit ? line_buf[disp_bank][xcnt_q[9:1]] : 12'h000;

   // T*320 as (T<<8)+(T<<6).
   assign bus.mem_req  = (state_q == FETCH);
   assign bus.busy     = (state_q != IDLE);
   assign bus.overrun  = ovr_q;
   assign bus.mem_addr = (state_q == FETCH)
                       ? BASE + ADDR_W'({tgt_q, 8'b0}) + ADDR_W'({tgt_q, 6'b0}) + ADDR_W'(idx_q)
                       : '0;
endmodule

// File: tb/tb_vga_linefetch.sv
// Bench for vga_linefetch: vector table, directed corner sequences and randomized lines vs a transaction model.
module tb_vga_linefetch;
   localparam int              ADDR_W = 17;
   localparam logic [16:0]     BASE   = 17'h00000;
   localparam int              LINES  = 240;
   localparam int              WIDTH  = 320;
`ifdef VGA_LINEFETCH_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #20 clk = ~clk;

   vga_linefetch_if #(.ADDR_W(ADDR_W)) ifc ();

   vga_linefetch #(.ADDR_W(ADDR_W), .BASE(BASE), .LINES(LINES), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   int checks = 0;
   int failures = 0;

   // Model: which line each bank holds, its words, and the fetch in flight.
   int m_tag [2];
   int m_buf [2][WIDTH];
   bit m_fetch, m_abort, m_gap, m_ovr;
   int m_t, m_idx, m_pend, m_x;
   int ack_div;
   int cyc;
   bit g_ack;

   typedef struct {
      logic [7:0]  line;
      bit          exp_req;
      logic [16:0] exp_addr;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_tag[0] = -1; m_tag[1] = -1;
      m_fetch = 0; m_abort = 0; m_gap = 0; m_ovr = 0;
      m_t = 0; m_idx = 0; m_pend = 0; m_x = 0;
   endtask

   task automatic m_start(input int t);
      if (t >= LINES) return;
      if (SKIP && m_tag[t % 2] == t) return;
      m_fetch = 1; m_t = t; m_idx = 0; m_tag[t % 2] = -1;
   endtask

   task automatic m_edge(input bit nl, input bit adv, input bit ack, input int l);
      int t;
      t = (l + 1) % 256;
      if (m_gap) begin
         m_gap = 0;
         m_start(nl ? t : m_pend);
      end else if (m_fetch) begin
         if (nl) begin m_ovr = 1; m_abort = 1; m_pend = t; end
         if (ack) begin
            if (m_abort) begin
               m_fetch = 0; m_abort = 0; m_gap = 1;
            end else begin
               m_buf[m_t % 2][m_idx] = (int'(BASE) + m_t * WIDTH + m_idx) % 4096;
               m_idx++;
               if (m_idx == WIDTH) begin m_tag[m_t % 2] = m_t; m_fetch = 0; end
            end
         end
      end else if (nl) begin
         m_start(t);
      end
      if (nl) m_x = 0;
      else if (adv && m_x < 2 * WIDTH - 1) m_x++;
   endtask

   function automatic int exp_pixel();
      int l;
      l = int'(ifc.line);
      return (m_tag[l % 2] == l) ? m_buf[l % 2][m_x / 2] : 0;
   endfunction

   // One clock: drive inputs at the falling edge, check outputs, advance the model on the rising edge.
   task automatic step(input bit nl, input bit adv);
      bit ack;
      ifc.newline = nl;
      ifc.advance = adv;
      if (ack_div == 0) ack = ifc.mem_req && ($urandom_range(3) != 0);
      else              ack = ifc.mem_req && (cyc % ack_div == 0);
      ifc.mem_ack   = ack;
      ifc.mem_rdata = ifc.mem_addr[11:0];
      #1;
      chk("mem_req", ifc.mem_req, m_fetch);
      chk("busy", ifc.busy, m_fetch || m_gap);
      chk("overrun", ifc.overrun, m_ovr);
      chk("pixel", ifc.pixel, exp_pixel());
      if (m_fetch) chk("mem_addr", ifc.mem_addr, int'(BASE) + m_t * WIDTH + m_idx);
      @(posedge clk);
      m_edge(nl, adv, ack, int'(ifc.line));
      g_ack = ack;
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit adv);
      for (int i = 0; i < n; i++) step(1'b0, adv);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, bad, prev;
      logic [7:0] l;

      tbl[0] = '{8'hFF, 1'b1, 17'd0};
      tbl[1] = '{8'h00, 1'b1, 17'd320};
      tbl[2] = '{8'h05, 1'b1, 17'd1920};
      tbl[3] = '{8'hEE, 1'b1, 17'd76480};
      tbl[4] = '{8'hEF, 1'b0, 17'd0};
      tbl[5] = '{8'hF0, 1'b0, 17'd0};
      tbl[6] = '{8'hFE, 1'b0, 17'd0};

      ifc.newline = 0; ifc.advance = 0; ifc.line = 0; ifc.mem_ack = 0; ifc.mem_rdata = 0;
      ack_div = 1; cyc = 0; g_ack = 0;
      m_reset();

      repeat (2) @(negedge clk);
      chk("rst_mem_req", ifc.mem_req, 0);
      chk("rst_mem_addr", ifc.mem_addr, 0);
      chk("rst_pixel", ifc.pixel, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_overrun", ifc.overrun, 0);
      reset = 0;
      @(negedge clk);

      // Target rule and first address per newline.
      foreach (tbl[i]) begin
         ifc.line = tbl[i].line;
         step(1'b1, 1'b0);
         chk("tbl_req", ifc.mem_req, tbl[i].exp_req);
         if (tbl[i].exp_req) chk("tbl_addr", ifc.mem_addr, tbl[i].exp_addr);
         run(340, 1'b0);
      end

      // Line 0 load then doubled display while line 1 fills.
      ifc.line = 8'hFF; step(1'b1, 1'b0); run(400, 1'b0);
      chk("fill_overrun", ifc.overrun, 0);
      ifc.line = 8'h00; step(1'b1, 1'b0);
      bad = 0;
      for (int j = 0; j < 640; j++) begin
         if (ifc.pixel !== 12'(j / 2)) bad++;
         step(1'b0, 1'b1);
      end
      chk("pix_seq_bad", bad, 0);
      step(1'b0, 1'b1); step(1'b0, 1'b1);
      chk("pix_saturate", ifc.pixel, 319);
      run(160, 1'b0);

      // Vblank targets never fetch.
      ifc.line = 8'hEF; step(1'b1, 1'b0);
      cnt = 0;
      for (int j = 0; j < 799; j++) begin cnt += int'(ifc.mem_req); step(1'b0, 1'b0); end
      chk("vblank_t240_req", cnt, 0);
      ifc.line = 8'hF0; step(1'b1, 1'b0);
      cnt = 0;
      for (int j = 0; j < 799; j++) begin cnt += int'(ifc.mem_req); step(1'b0, 1'b0); end
      chk("vblank_t241_req", cnt, 0);

      // Slow memory: overrun, hold until ack, one-cycle gap, restart on the new target.
      ack_div = 4;
      ifc.line = 8'd9; step(1'b1, 1'b0); run(799, 1'b0);
      ifc.line = 8'd10; step(1'b1, 1'b1);
      chk("ovr_flag", ifc.overrun, 1);
      for (int k = 0; k < 8 && ifc.mem_req; k++) step(1'b0, 1'b1);
      chk("ovr_req_drop", ifc.mem_req, 0);
      chk("ovr_drop_on_ack", g_ack, 1);
      step(1'b0, 1'b1);
      chk("ovr_resume_req", ifc.mem_req, 1);
      chk("ovr_resume_addr", ifc.mem_addr, 17'd3520);
      bad = 0;
      for (int j = 0; j < 640; j++) begin
         if (ifc.pixel !== 12'h000) bad++;
         step(1'b0, 1'b1);
      end
      chk("aborted_line_pix", bad, 0);
      run(1400, 1'b0);

      // Reset in the middle of a fill.
      ack_div = 1;
      reset = 1; @(negedge clk); reset = 0; m_reset();
      ifc.line = 8'hFF; step(1'b1, 1'b0); run(340, 1'b0);
      ifc.line = 8'h00; step(1'b1, 1'b0);
      for (int k = 0; k < 200 && !(m_fetch && m_idx == 100); k++) step(1'b0, 1'b1);
      chk("pre_rst_addr", ifc.mem_addr, 17'd420);
      chk("pre_rst_pixel_nz", ifc.pixel != 12'h000, 1);
      #2 reset = 1;
      #1;
      chk("mid_rst_req", ifc.mem_req, 0);
      chk("mid_rst_busy", ifc.busy, 0);
      chk("mid_rst_pixel", ifc.pixel, 0);
      ifc.mem_ack = 0; ifc.newline = 0; ifc.advance = 0;
      @(negedge clk); @(negedge clk);
      reset = 0; m_reset();
      chk("post_rst_busy", ifc.busy, 0);
      chk("post_rst_req", ifc.mem_req, 0);
      ifc.line = 8'h00; step(1'b1, 1'b0);
      bad = 0;
      for (int j = 0; j < 100; j++) begin
         if (ifc.pixel !== 12'h000) bad++;
         step(1'b0, 1'b1);
      end
      chk("post_rst_pix", bad, 0);
      run(300, 1'b0);

      // Same line twice in a row.
      cnt = 0;
      ifc.line = 8'd5; step(1'b1, 1'b0);
      for (int j = 0; j < 400; j++) begin step(1'b0, 1'b0); cnt += int'(g_ack); end
      ifc.line = 8'd5; step(1'b1, 1'b0); cnt += int'(g_ack);
      for (int j = 0; j < 400; j++) begin step(1'b0, 1'b0); cnt += int'(g_ack); end
      chk("repeat_line_acks", cnt, SKIP ? 320 : 640);

      // Randomized scanlines with random ack stalls and advance gaps.
      ack_div = 0;
      prev = 5;
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(3))
            0: l = 8'(prev + 1);
            1: l = 8'(prev);
            2: l = 8'($urandom_range(255));
            default: l = 8'($urandom_range(255, 238));
         endcase
         prev = int'(l);
         ifc.line = l;
         step(1'b1, 1'b0);
         for (int k = 0; k < 799; k++) step(1'b0, (k < 700) && ($urandom_range(7) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_linefetch.md
Name: vga_linefetch

Overview:
- Scanline fetch controller sitting between the 640x480 VGA timing generator and the shared pixel memory.
- Displays a 320x240 12-bit framebuffer pixel-doubled in both axes.
- On each timing `newline` it fetches the next framebuffer line from memory into one half of a two-bank line buffer (ping-pong).
- At the same time it serves `pixel` from the other bank as the timing generator pulses `advance`.

Parameters:
- BASE, 17'h00000: word address of framebuffer line 0.
- ADDR_W, 17: memory address width.
- LINES, 240: framebuffer lines. Targets >= LINES are never fetched.
- WIDTH, 320: words per line. Each word is shown for 2 pixels.

Ports:
- clk  in  1  system clock (25MHz pixel clock)
- reset  in  1  asynchronous, active-high reset
- newline  in  1  one-cycle pulse at start of each 800-clock scanline
- advance  in  1  high for each cycle the timing generator consumes `pixel`
- line  in  8  current display line (0..239 active; 240..255 in vblank)
- pixel  out  12  RGB444 to timing generator
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read word address
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid this cycle
- mem_rdata  in  12  read data
- busy  out  1  fetch in progress
- overrun  out  1  sticky: a newline arrived before the fetch completed

Behaviour:
- Reset values (async assert, all outputs and state): mem_req=0, mem_addr=0, pixel=0, busy=0, overrun=0, bank tags invalid, state IDLE.
- Target on newline with line=L: T = L+1, 8-bit wrap (0xFF -> 0). Fetch only if T < LINES. Bank = T[0]. Display bank = L[0], so fill and display banks always differ.
- State IDLE:
  - newline with a valid T: latch T; clear the tag of bank T[0]; set idx=0; go to FETCH.
  - newline with T >= LINES: no fetch, stay IDLE.
- State FETCH:
  - mem_req=1 and busy=1.
  - mem_addr = BASE + T*320 + idx, with T*320 formed as (T<<8)+(T<<6).
  - mem_req and mem_addr are held stable until mem_ack.
  - On mem_ack: buf[T[0]][idx] <= mem_rdata and idx++.
  - On mem_ack with idx==WIDTH-1: tag[T[0]] <= T (valid), mem_req=0, go to IDLE.
- Overrun: newline while in FETCH:
  - set overrun=1.
  - latch the new target as pending; the bank of the interrupted fill stays tag-invalid.
  - The outstanding request is still completed: mem_req never drops before mem_ack.
  - At that ack go to RESTART (mem_req=0 for one cycle), then FETCH the pending target with idx=0.
  - If the pending T >= LINES, go to IDLE instead.
- Display:
  - xcount resets to 0 on newline and increments on each cycle with advance=1, saturating at 639.
  - In any cycle, pixel = buf[L[0]][xcount>>1] if tag[L[0]]==L and valid, else 12'h000.
  - The value is valid combinationally in the same cycle, because the consumer samples pixel on the edge where it raises advance.
  - So the sequence seen by the timing generator is w0,w0,w1,w1,...,w319,w319.
- The buffer read and write ports are independent. A write and a read in the same cycle never target the same bank.
- mem_ack while in IDLE or RESTART is ignored.

Optional Feature:
- VGA_LINEFETCH_SKIP_EN defined:
  - Keep the last completed target as a tag.
  - On a newline whose T equals a valid tag in bank T[0], do not fetch: no mem_req, no tag clear, stay IDLE.
  - This halves memory traffic because each line is displayed twice.
- Undefined: every newline with T < LINES refetches.

Test Plan:
- Reset mid-FETCH (idx=100): mem_req, busy, and pixel go to 0 immediately. After release: IDLE, tags invalid, pixel=0 on a subsequent line=0.
- newline with line=0xFF, mem_ack every cycle, rdata=idx -> 320 requests at BASE+0..319; busy high for 320+ cycles, then 0; overrun=0.
- Then newline with line=0 and 640 advance cycles -> pixel sequence 0,0,1,1,...,319,319. Concurrently a fetch of line 1 runs at BASE+320..639.
- newline with line=0xEF (239) -> T=240; mem_req stays 0 for 800 cycles. Next newline with line=0xF0 -> T=241, also no fetch.
- mem_ack every 4th cycle (needs 1280 > 800 cycles):
  - second newline -> overrun=1; mem_req held until the pending ack, 1-cycle gap, then addresses restart at BASE+T2*320.
  - Displaying the aborted line yields pixel=0 for all 640 cycles.
- Two consecutive newlines with line=5:
  - VGA_LINEFETCH_SKIP_EN defined -> exactly 320 requests total.
  - Undefined -> 640 requests, both at BASE+1920..2239.
